// File: rtl/shift_rotate_unit_pkg.sv
// Shared encodings for the shift/rotate engine: operation modes, FSM states
// and a helper that flags the reserved mode codes.
package shift_rotate_unit_pkg;

   typedef enum logic [2:0] {
      SR_SHR  = 3'b000,
      SR_SHRA = 3'b001,
      SR_SHL  = 3'b010,
      SR_ROR  = 3'b011,
      SR_ROL  = 3'b100
   } sr_mode_e;

   typedef enum logic [1:0] {
      SR_IDLE  = 2'b00,
      SR_SHIFT = 2'b01,
      SR_DONE  = 2'b10
   } sr_state_e;

   function automatic logic sr_mode_reserved(input logic [2:0] mode);
      return (mode > 3'b100);
   endfunction

endpackage

// File: rtl/shift_rotate_unit_if.sv
// Request/response bundle between the datapath and the shift/rotate engine.
interface shift_rotate_unit_if #(
   parameter int WIDTH = 32
) ();
   localparam int SHAMT_W = $clog2(WIDTH);

   logic               start;
   logic [2:0]         mode;
   logic [WIDTH-1:0]   operand;
   logic [SHAMT_W-1:0] shamt;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   result;
   logic               carry;

   modport master (
      output start, mode, operand, shamt,
      input  busy, done, result, carry
   );

   modport slave (
      input  start, mode, operand, shamt,
      output busy, done, result, carry
   );
endinterface

// File: rtl/shift_rotate_unit_shift_step.sv
// Combinational single step: shifts or rotates a value by k bits (k >= 1)
// and reports the bit that leaves the word on that step.
module shift_rotate_unit_shift_step
   import shift_rotate_unit_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]   value,
   input  logic [SHAMT_W-1:0] k,
   input  logic [2:0]         mode,
   output logic [WIDTH-1:0]   next_value,
   output logic               carry_out
);

   // one k-bit step; k==0 or a reserved mode passes the value through
   always_comb begin
      next_value = value;
      carry_out  = 1'b0;
      if (k != {SHAMT_W{1'b0}}) begin
         case (mode)
            SR_SHR: begin
               next_value = value >> k;
               carry_out  = value[SHAMT_W'(int'(k) - 1)];
            end
            SR_SHRA: begin
               next_value = $signed(value) >>> k;
               carry_out  = value[SHAMT_W'(int'(k) - 1)];
            end
            SR_SHL: begin
               next_value = value << k;
               carry_out  = value[SHAMT_W'(WIDTH - int'(k))];
            end
            SR_ROR: begin
               for (int i = 0; i < WIDTH; i++) begin
                  next_value[i] = value[SHAMT_W'((i + int'(k)) % WIDTH)];
               end
               carry_out = next_value[WIDTH-1];
            end
            SR_ROL: begin
               for (int i = 0; i < WIDTH; i++) begin
                  next_value[i] = value[SHAMT_W'((i + WIDTH - int'(k)) % WIDTH)];
               end
               carry_out = next_value[0];
            end
            default: begin
               next_value = value;
               carry_out  = 1'b0;
            end
         endcase
      end else begin
         next_value = value;
         carry_out  = 1'b0;
      end
   end

endmodule

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate engine: IDLE/SHIFT/DONE FSM moving up to STEP bits
// per cycle, with a start/busy/done handshake and a held result.
module shift_rotate_unit
   import shift_rotate_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input  logic              clk,
   input  logic              clr,
   shift_rotate_unit_if.slave bus
);

   localparam int SHAMT_W = $clog2(WIDTH);
   // the count never exceeds WIDTH-1, so clamping STEP there keeps min() exact
   localparam int unsigned STEP_CAP = (STEP > WIDTH - 1) ? (WIDTH - 1) : STEP;
   localparam logic [SHAMT_W-1:0] STEP_V = STEP_CAP[SHAMT_W-1:0];

   sr_state_e          state_r;
   sr_state_e          next_state_s;
   logic [WIDTH-1:0]   result_r;
   logic               carry_r;
   logic [2:0]         mode_r;
   logic [SHAMT_W-1:0] cnt_r;
   logic               busy_r;
   logic               done_r;
   logic [SHAMT_W-1:0] k_s;
   logic [WIDTH-1:0]   step_value_s;
   logic               step_carry_s;

   assign k_s = (cnt_r > STEP_V) ? STEP_V : cnt_r;

   shift_rotate_unit_shift_step #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W)
   ) u_step (
      .value      (result_r),
      .k          (k_s),
      .mode       (mode_r),
      .next_value (step_value_s),
      .carry_out  (step_carry_s)
   );

   // next-state decode
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         SR_IDLE: begin
            if (bus.start) begin
               if ((bus.shamt == {SHAMT_W{1'b0}}) || sr_mode_reserved(bus.mode)) begin
                  next_state_s = SR_DONE;
               end else begin
                  next_state_s = SR_SHIFT;
               end
            end else begin
               next_state_s = SR_IDLE;
            end
         end
         SR_SHIFT: begin
            if (cnt_r == k_s) begin
               next_state_s = SR_DONE;
            end else begin
               next_state_s = SR_SHIFT;
            end
         end
         SR_DONE:  next_state_s = SR_IDLE;
         default:  next_state_s = SR_IDLE;
      endcase
   end

   // state, datapath and handshake registers
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_r  <= SR_IDLE;
         result_r <= {WIDTH{1'b0}};
         carry_r  <= 1'b0;
         mode_r   <= 3'b000;
         cnt_r    <= {SHAMT_W{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r <= next_state_s;
         busy_r  <= (next_state_s == SR_SHIFT);
         done_r  <= (next_state_s == SR_DONE);
         case (state_r)
            SR_IDLE: begin
               if (bus.start) begin
                  result_r <= bus.operand;
                  carry_r  <= 1'b0;
                  mode_r   <= bus.mode;
                  cnt_r    <= bus.shamt;
               end
            end
            SR_SHIFT: begin
               result_r <= step_value_s;
               carry_r  <= step_carry_s;
               cnt_r    <= cnt_r - k_s;
            end
            default: begin
               result_r <= result_r;
            end
         endcase
      end
   end

   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.result = result_r;
   assign bus.carry  = carry_r;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed bench for shift_rotate_unit: STEP=1 and STEP=4 instances checked
// against an arithmetic reference model and hand-computed vectors.
module tb_shift_rotate_unit;

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   shift_rotate_unit_if #(.WIDTH(32)) bus1 ();
   shift_rotate_unit_if #(.WIDTH(32)) bus4 ();

   shift_rotate_unit #(.WIDTH(32), .STEP(1)) dut1 (.clk(clk), .clr(clr), .bus(bus1));
   shift_rotate_unit #(.WIDTH(32), .STEP(4)) dut4 (.clk(clk), .clr(clr), .bus(bus4));

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      int          step;
      logic [2:0]  m;
      logic [31:0] op;
      int          s;
      bit          lit;
      logic [31:0] lres;
      logic        lc;
      int          ln;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // reference: whole-shift arithmetic, latency = ceil(shamt/STEP)
   task automatic model(input logic [2:0] m, input logic [31:0] op, input int s, input int step,
                        output logic [31:0] r, output logic c, output int n);
      logic [31:0] t;
      r = op; c = 1'b0; n = 0;
      if (s != 0 && m <= 3'd4) begin
         n = (s + step - 1) / step;
         case (m)
            3'd0: begin r = op >> s; t = op >> (s - 1); c = t[0]; end
            3'd1: begin r = $signed(op) >>> s; t = op >> (s - 1); c = t[0]; end
            3'd2: begin r = op << s; t = op << (s - 1); c = t[31]; end
            3'd3: begin r = (op >> s) | (op << (32 - s)); c = r[31]; end
            default: begin r = (op << s) | (op >> (32 - s)); c = r[0]; end
         endcase
      end
   endtask

   task automatic drive(input int sel, input logic st, input logic [2:0] m,
                        input logic [31:0] op, input int s);
      if (sel == 4) begin
         bus4.start = st; bus4.mode = m; bus4.operand = op; bus4.shamt = 5'(s);
      end else begin
         bus1.start = st; bus1.mode = m; bus1.operand = op; bus1.shamt = 5'(s);
      end
   endtask

   task automatic sample(input int sel, output logic b, output logic d,
                         output logic [31:0] r, output logic c);
      if (sel == 4) begin
         b = bus4.busy; d = bus4.done; r = bus4.result; c = bus4.carry;
      end else begin
         b = bus1.busy; d = bus1.done; r = bus1.result; c = bus1.carry;
      end
   endtask

   // busy and done must never overlap on either instance
   always @(negedge clk) begin
      if (clr === 1'b0) begin
         check("busy_done_excl1", 32'(bus1.busy & bus1.done), 32'd0);
         check("busy_done_excl4", 32'(bus4.busy & bus4.done), 32'd0);
      end
   end

   task automatic run_op(input int step, input logic [2:0] m, input logic [31:0] op,
                         input int s, input bit glitch,
                         output logic [31:0] r, output logic c, output int n);
      logic [31:0] er;
      logic        ec;
      int          en;
      logic        b, d;
      model(m, op, s, step, er, ec, en);
      @(negedge clk);
      drive(step, 1'b1, m, op, s);
      @(negedge clk);
      drive(step, 1'b0, m, op, s);
      n = 0;
      forever begin
         sample(step, b, d, r, c);
         if (d || n >= 64) break;
         if (glitch && n == 2) drive(step, 1'b1, 3'd2, ~op, 7);
         if (glitch && n == 3) drive(step, 1'b0, m, op, s);
         @(negedge clk);
         n++;
      end
      check("done_seen", 32'(d), 32'd1);
      check("latency", 32'(n), 32'(en));
      check("result", r, er);
      check("carry", 32'(c), 32'(ec));
      for (int i = 0; i < (glitch ? 4 : 1); i++) begin
         logic [31:0] rh;
         logic        ch;
         @(negedge clk);
         sample(step, b, d, rh, ch);
         check("done_pulse", 32'(d), 32'd0);
         check("result_held", rh, er);
      end
   endtask

   initial begin
      logic [31:0] r, mr;
      logic        c, mc, b, d;
      int          n, mn;

      tbl.push_back('{1, 3'd4, 32'h000000DB, 2, 1'b1, 32'h0000036C, 1'b0, 2});
      tbl.push_back('{1, 3'd4, 32'h80000001, 1, 1'b1, 32'h00000003, 1'b1, 1});
      tbl.push_back('{1, 3'd2, 32'h80000001, 1, 1'b1, 32'h00000002, 1'b1, 1});
      tbl.push_back('{4, 3'd3, 32'h00000001, 4, 1'b1, 32'h10000000, 1'b0, 1});
      tbl.push_back('{4, 3'd3, 32'h00000001, 6, 1'b1, 32'h04000000, 1'b0, 2});
      tbl.push_back('{1, 3'd1, 32'hF0000000, 8, 1'b1, 32'hFFF00000, 1'b0, 8});
      tbl.push_back('{1, 3'd0, 32'hF0000000, 8, 1'b1, 32'h00F00000, 1'b0, 8});
      tbl.push_back('{1, 3'd4, 32'h12345678, 0, 1'b1, 32'h12345678, 1'b0, 0});
      tbl.push_back('{1, 3'd7, 32'h12345678, 5, 1'b1, 32'h12345678, 1'b0, 0});
      tbl.push_back('{4, 3'd1, 32'h80000000, 31, 1'b1, 32'hFFFFFFFF, 1'b0, 8});
      tbl.push_back('{4, 3'd2, 32'hA5A5A5A5, 13, 1'b0, 32'h0, 1'b0, 0});
      tbl.push_back('{4, 3'd4, 32'hDEADBEEF, 7, 1'b0, 32'h0, 1'b0, 0});
      tbl.push_back('{1, 3'd3, 32'h0000000F, 3, 1'b0, 32'h0, 1'b0, 0});
      tbl.push_back('{4, 3'd0, 32'hFFFFFFFF, 31, 1'b0, 32'h0, 1'b0, 0});
      tbl.push_back('{1, 3'd2, 32'h00000001, 31, 1'b0, 32'h0, 1'b0, 0});
      tbl.push_back('{4, 3'd5, 32'hCAFEF00D, 9, 1'b0, 32'h0, 1'b0, 0});
      tbl.push_back('{4, 3'd2, 32'h12345678, 0, 1'b0, 32'h0, 1'b0, 0});

      clr = 1'b1;
      drive(1, 1'b0, 3'd0, 32'h0, 0);
      drive(4, 1'b0, 3'd0, 32'h0, 0);
      @(negedge clk);
      @(negedge clk);
      sample(1, b, d, r, c);
      check("reset_state1", {r[29:0], b, d} | 32'(c), 32'd0);
      sample(4, b, d, r, c);
      check("reset_state4", {r[29:0], b, d} | 32'(c), 32'd0);
      clr = 1'b0;

      foreach (tbl[i]) begin
         run_op(tbl[i].step, tbl[i].m, tbl[i].op, tbl[i].s, 1'b0, r, c, n);
         if (tbl[i].lit) begin
            model(tbl[i].m, tbl[i].op, tbl[i].s, tbl[i].step, mr, mc, mn);
            check("model_lit_result", mr, tbl[i].lres);
            check("model_lit_latency", 32'(mn), 32'(tbl[i].ln));
            check("lit_result", r, tbl[i].lres);
            check("lit_carry", 32'(c), 32'(tbl[i].lc));
            check("lit_latency", 32'(n), 32'(tbl[i].ln));
         end
      end

      // a start pulse during SHIFT must be ignored
      run_op(1, 3'd4, 32'h000000DB, 10, 1'b1, r, c, n);
      check("glitch_result", r, 32'h00036C00);

      // asynchronous clear mid-operation
      @(negedge clk);
      drive(1, 1'b1, 3'd4, 32'h000000DB, 20);
      @(negedge clk);
      drive(1, 1'b0, 3'd4, 32'h000000DB, 20);
      repeat (3) @(negedge clk);
      sample(1, b, d, r, c);
      check("busy_before_clr", 32'(b), 32'd1);
      #2 clr = 1'b1;
      #1;
      sample(1, b, d, r, c);
      check("clr_busy", 32'(b), 32'd0);
      check("clr_done", 32'(d), 32'd0);
      check("clr_result", r, 32'd0);
      check("clr_carry", 32'(c), 32'd0);
      #1 clr = 1'b0;
      run_op(1, 3'd4, 32'h00000001, 1, 1'b0, r, c, n);
      check("after_clr_result", r, 32'h00000002);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
